// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered 32-bit integer ALU for the MIPS execute stage.
//
// Computes AND, OR, add, sub, slt, NOR, sll and (optionally) rotate-left
// from two operands, a 4-bit control code and a 5-bit shift amount. Result
// and flags are registered once, feeding the EX/MEM boundary (1-cycle latency,
// one new operation per cycle, no enable).
//
// Configuration:
//   ALU_ROTATE_EN  defined   -> code 1110 rotates data2 left by shamt
//                  undefined -> no rotator; 1110 is an unsupported code
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst            in   1   asynchronous active-high reset
//   data1          in  32   operand A (rs)
//   data2          in  32   operand B (rt; shift/rotate source)
//   ALU_Control    in   4   operation select
//   shamt          in   5   shift/rotate amount 0..31
//   ALU_result     out 32   registered result (0 on unsupported code)
//   Control_error  out  1   registered; 1 on unsupported code
//   zero           out  1   registered; 1 when ALU_result is 0
// ---------------------------------------------------------------------------
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [3:0]  ALU_Control,
    input  logic [4:0]  shamt,
    output logic [31:0] ALU_result,
    output logic        Control_error,
    output logic        zero
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1100,
        OP_SLL = 4'b1101,
        OP_RLL = 4'b1110
    } alu_op_e;

    logic [31:0] nxt_result;
    logic        nxt_error;

    always_comb begin
        nxt_result = '0;
        nxt_error  = 1'b0;
        case (alu_op_e'(ALU_Control))
            OP_AND: nxt_result = data1 & data2;
            OP_OR:  nxt_result = data1 | data2;
            OP_ADD: nxt_result = data1 + data2;
            OP_SUB: nxt_result = data1 - data2;
            // Signed compare directly, so subtraction overflow cannot flip the answer.
            OP_SLT: nxt_result = {31'd0, ($signed(data1) < $signed(data2))};
            OP_NOR: nxt_result = ~(data1 | data2);
            OP_SLL: nxt_result = data2 << shamt;
`ifdef ALU_ROTATE_EN
            // For shamt = 0 the right shift is by 32, contributing nothing.
            OP_RLL: nxt_result = (data2 << shamt) |
                                 (data2 >> (6'd32 - {1'b0, shamt}));
`endif
            default: begin
                nxt_result = '0;
                nxt_error  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_result    <= '0;
            Control_error <= 1'b0;
            zero          <= 1'b1;
        end else begin
            ALU_result    <= nxt_result;
            Control_error <= nxt_error;
            zero          <= (nxt_result == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu: directed cases plus randomized
// operations compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [3:0]  ALU_Control;
    logic [4:0]  shamt;
    logic [31:0] ALU_result;
    logic        Control_error;
    logic        zero;

    int checks = 0;
    int errors = 0;

    alu dut (
        .clk           (clk),
        .rst           (rst),
        .data1         (data1),
        .data2         (data2),
        .ALU_Control   (ALU_Control),
        .shamt         (shamt),
        .ALU_result    (ALU_result),
        .Control_error (Control_error),
        .zero          (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam longint unsigned TWO32 = 64'h1_0000_0000;

    // Reference model: plain integer arithmetic from the operation table.
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh,
                                  output logic [31:0] r, output logic err);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint unsigned scaled;
        longint          sa;
        longint          sb;
        sa = a[31] ? longint'(ua) - longint'(TWO32) : longint'(ua);
        sb = b[31] ? longint'(ub) - longint'(TWO32) : longint'(ub);
        scaled = ub * (64'd1 << sh);
        err = 1'b0;
        r   = 32'd0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = 32'((ua + ub) % TWO32);
            4'b0110: r = 32'((ua + TWO32 - ub) % TWO32);
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            4'b1101: r = 32'(scaled % TWO32);
`ifdef ALU_ROTATE_EN
            4'b1110: r = 32'((scaled % TWO32) + (scaled / TWO32));
`endif
            default: begin
                r   = 32'd0;
                err = 1'b1;
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] r,
                             input logic err, input logic z);
        check({tag, ".result"}, ALU_result, r);
        check({tag, ".error"}, {31'd0, Control_error}, {31'd0, err});
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic apply(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        @(negedge clk);
        ALU_Control = op;
        data1       = a;
        data2       = b;
        shamt       = sh;
        @(posedge clk);
        #1;
    endtask

    task automatic run_model(input string tag, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] sh);
        logic [31:0] r;
        logic        e;
        model(op, a, b, sh, r, e);
        apply(op, a, b, sh);
        check_out(tag, r, e, (r == 32'd0));
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;

        rst         = 1'b1;
        data1       = 32'hDEAD_BEEF;
        data2       = 32'h1234_5678;
        ALU_Control = 4'b0001;
        shamt       = 5'd3;
        @(posedge clk);
        #1;
        check_out("reset_hold", 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Directed sweep, one code per cycle.
        apply(4'b0000, 32'h0000_1100, 32'h0001_1000, 5'd4);
        check_out("sweep_and", 32'h0000_1000, 1'b0, 1'b0);
        apply(4'b0001, 32'h0000_1100, 32'h0001_1000, 5'd4);
        check_out("sweep_or", 32'h0001_1100, 1'b0, 1'b0);
        apply(4'b0010, 32'h0000_1100, 32'h0001_1000, 5'd4);
        check_out("sweep_add", 32'h0001_2100, 1'b0, 1'b0);
        apply(4'b0110, 32'h0000_1100, 32'h0001_1000, 5'd4);
        check_out("sweep_sub", 32'hFFFF_0100, 1'b0, 1'b0);
        apply(4'b0111, 32'h0000_1100, 32'h0001_1000, 5'd4);
        check_out("sweep_slt", 32'h0000_0001, 1'b0, 1'b0);
        apply(4'b1100, 32'h0000_1100, 32'h0001_1000, 5'd4);
        check_out("sweep_nor", 32'hFFFE_EEFF, 1'b0, 1'b0);
        apply(4'b1101, 32'h0000_1100, 32'h0001_1000, 5'd4);
        check_out("sweep_sll", 32'h0011_0000, 1'b0, 1'b0);
        apply(4'b1110, 32'h0000_1100, 32'h0001_1000, 5'd4);
`ifdef ALU_ROTATE_EN
        check_out("sweep_rll", 32'h0011_0000, 1'b0, 1'b0);
`else
        check_out("sweep_rll_off", 32'd0, 1'b1, 1'b1);
`endif

        // Signed and wrap corners.
        apply(4'b0111, 32'h8000_0000, 32'h0000_0001, 5'd0);
        check_out("slt_neg_pos", 32'd1, 1'b0, 1'b0);
        apply(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0);
        check_out("slt_pos_neg", 32'd0, 1'b0, 1'b1);
        apply(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9);
        check_out("add_wrap", 32'd0, 1'b0, 1'b1);
        apply(4'b0110, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 5'd2);
        check_out("sub_equal", 32'd0, 1'b0, 1'b1);

        // Shifts.
        apply(4'b1110, 32'h0, 32'h8000_0001, 5'd1);
`ifdef ALU_ROTATE_EN
        check_out("rll_1", 32'h0000_0003, 1'b0, 1'b0);
`else
        check_out("rll_1_off", 32'd0, 1'b1, 1'b1);
`endif
        apply(4'b1101, 32'h0, 32'h8000_0001, 5'd1);
        check_out("sll_1", 32'h0000_0002, 1'b0, 1'b0);
        apply(4'b1101, 32'h0, 32'h8000_0001, 5'd0);
        check_out("sll_0", 32'h8000_0001, 1'b0, 1'b0);
        apply(4'b1101, 32'h0, 32'h0000_0001, 5'd31);
        check_out("sll_31", 32'h8000_0000, 1'b0, 1'b0);
`ifdef ALU_ROTATE_EN
        apply(4'b1110, 32'h0, 32'h8000_0001, 5'd0);
        check_out("rll_0", 32'h8000_0001, 1'b0, 1'b0);
        apply(4'b1110, 32'h0, 32'h0000_0001, 5'd31);
        check_out("rll_31", 32'h8000_0000, 1'b0, 1'b0);
`endif

        // Unsupported codes.
        apply(4'b0011, 32'hFFFF_FFFF, 32'h1234_5678, 5'd7);
        check_out("bad_0011", 32'd0, 1'b1, 1'b1);
        apply(4'b1111, 32'hFFFF_FFFF, 32'h1234_5678, 5'd7);
        check_out("bad_1111", 32'd0, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle discards the held result.
        apply(4'b0001, 32'h0F0F_0000, 32'h0000_F0F0, 5'd0);
        check_out("pre_reset", 32'h0F0F_F0F0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_reset", 32'd0, 1'b0, 1'b1);
        apply(4'b0011, 32'h1, 32'h2, 5'd0);
        check_out("reset_held", 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        rst         = 1'b0;
        ALU_Control = 4'b0010;
        data1       = 32'h0000_0005;
        data2       = 32'h0000_0007;
        @(posedge clk);
        #1;
        check_out("first_after_release", 32'h0000_000C, 1'b0, 1'b0);

        // Randomized back-to-back operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
            if ($urandom_range(0, 5) == 0) a = {a[31], 31'd0};
            sh = 5'($urandom_range(0, 31));
            run_model("random", op, a, b, sh);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
